// File: rtl/seg_sub_pkg.sv
// rtl/seg_sub_pkg.sv - shared FSM state type and index-width helper for seg_sub.
package seg_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_sub_chunk.sv
// rtl/seg_sub_chunk.sv - combinational CHUNK-bit slice computing x + ~y + cin.
module seg_sub_chunk #(
    parameter int CHUNK = 64
) (
    input  logic [CHUNK-1:0] i_x,
    input  logic [CHUNK-1:0] i_y,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_d,
    output logic             o_cout
);

    assign {o_cout, o_d} = {1'b0, i_x} + {1'b0, ~i_y} + {{CHUNK{1'b0}}, i_cin};

endmodule

// File: rtl/seg_sub.sv
// rtl/seg_sub.sv - multi-cycle segmented subtractor, one CHUNK slice per clock.
// Optional signed-overflow output enabled by SEG_SUB_OVF_EN.
module seg_sub
    import seg_sub_pkg::*;
#(
    parameter int WIDTH = 512,
    parameter int CHUNK = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SEG_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? clog2(N) : 1;

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_width
            $fatal(1, "seg_sub: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_diff;
    logic [IW-1:0]    r_idx;
    logic             r_carry;
    logic             r_bout;
    logic [31:0]      w_base;
    logic [CHUNK-1:0] w_xs;
    logic [CHUNK-1:0] w_ys;
    logic [CHUNK-1:0] w_d;
    logic             w_cout;
    logic             w_last;

    assign w_base = 32'(r_idx) * 32'(CHUNK);
    assign w_xs   = r_x[w_base +: CHUNK];
    assign w_ys   = r_y[w_base +: CHUNK];
    assign w_last = (r_idx == IW'(N - 1));

    seg_sub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .i_x    (w_xs),
        .i_y    (w_ys),
        .i_cin  (r_carry),
        .o_d    (w_d),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next = RUN;
            RUN:     if (w_last)    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Carry holds the inverted borrow, so the chain is a plain add of ~y.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x     <= '0;
            r_y     <= '0;
            r_diff  <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_bout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_x     <= x;
                        r_y     <= y;
                        r_carry <= ~bin;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_diff[w_base +: CHUNK] <= w_d;
                    r_carry                 <= w_cout;
                    r_idx                   <= r_idx + 1'b1;
                    if (w_last) begin
                        r_bout <= ~w_cout;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SEG_SUB_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == RUN && w_last) begin
            r_ovf <= (w_xs[CHUNK-1] != w_ys[CHUNK-1]) && (w_d[CHUNK-1] != w_xs[CHUNK-1]);
        end
    end

    assign ovf = r_ovf;
`endif

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign diff      = r_diff;
    assign bout      = r_bout;

endmodule

// File: tb/tb_seg_sub.sv
// tb/tb_seg_sub.sv - randomized self-checking bench for seg_sub against a wide-arithmetic model.
module tb_seg_sub;

    localparam int WIDTH = 512;
    localparam int CHUNK = 64;
    localparam int N     = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SEG_SUB_OVF_EN
    logic             ovf;
`endif

    always #5 clk = ~clk;

    seg_sub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef SEG_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Behavioural model: result is plain wide arithmetic, timing is "N edges after accept".
    int               e = 0;
    int               m_t = 0;
    bit               m_busy = 1'b0;
    bit               m_known = 1'b0;
    bit               v_prev;
    logic [WIDTH-1:0] m_pend_d, m_diff;
    logic             m_pend_b, m_bout, m_pend_o, m_ovf;

    task automatic model_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bi);
        logic [WIDTH:0] r;
        r        = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bi};
        m_pend_d = r[WIDTH-1:0];
        m_pend_b = r[WIDTH];
        m_pend_o = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    endtask

    always @(posedge clk) begin
        v_prev = m_busy && (e >= m_t + N);
        e++;
        if (rst) begin
            m_busy  = 1'b0;
            m_diff  = '0;
            m_bout  = 1'b0;
            m_ovf   = 1'b0;
            m_known = 1'b1;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy  = 1'b1;
                m_t     = e;
                m_known = 1'b0;
                model_op(x, y, bin);
            end
        end else if (v_prev && out_ready) begin
            m_busy = 1'b0;
        end
        if (m_busy && e >= m_t + N) begin
            m_diff  = m_pend_d;
            m_bout  = m_pend_b;
            m_ovf   = m_pend_o;
            m_known = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (e > 0) begin
            chk("in_ready", WIDTH'(in_ready), WIDTH'(!m_busy));
            chk("out_valid", WIDTH'(out_valid), WIDTH'(m_busy && (e >= m_t + N)));
            if (m_known) begin
                chk("diff", diff, m_diff);
                chk("bout", WIDTH'(bout), WIDTH'(m_bout));
`ifdef SEG_SUB_OVF_EN
                chk("ovf", WIDTH'(ovf), WIDTH'(m_ovf));
`endif
            end
        end
    end

    function automatic logic [WIDTH-1:0] rnd_wide();
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH / 32; i++) r[i*32 +: 32] = $urandom;
        case ($urandom_range(0, 4))
            0: r = '0;
            1: r = '1;
            2: r = WIDTH'($urandom_range(0, 3)) << (CHUNK * $urandom_range(0, N - 1));
            default: ;
        endcase
        return r;
    endfunction

    logic [WIDTH-1:0] res_d;
    logic             res_b;

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bi,
                          input int hold, output logic [WIDTH-1:0] rd, output logic rb);
        int n;
        logic [WIDTH-1:0] held;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        chk("accept_timeout", WIDTH'(in_ready), WIDTH'(1));
        in_valid = 1'b1; x = a; y = b; bin = bi;
        @(posedge clk); #2;
        in_valid = 1'b0; x = rnd_wide(); y = rnd_wide(); bin = 1'($urandom);
        n = 0;
        while (!out_valid && n < 50) begin
            out_ready = 1'($urandom);
            in_valid  = 1'($urandom);
            @(posedge clk); #2;
            n++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("latency", WIDTH'(n), WIDTH'(N));
        held = diff;
        rb   = bout;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #2;
            chk("hold_diff", diff, held);
            chk("hold_bout", WIDTH'(bout), WIDTH'(rb));
            chk("hold_in_ready", WIDTH'(in_ready), WIDTH'(0));
        end
        rd = diff;
        out_ready = 1'b1;
        @(posedge clk); #2;
        out_ready = 1'b0;
        chk("release_idle", WIDTH'({in_ready, out_valid}), WIDTH'(2'b10));
    endtask

    initial begin
        logic [WIDTH-1:0] a, b, ones, msb;
        int seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0; bin = 1'b0;
        ones = '1;
        msb  = '0;
        msb[WIDTH-1] = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        chk("reset_state", WIDTH'({in_ready, out_valid, bout}), WIDTH'(3'b100));
        chk("reset_diff", diff, '0);

        run_op(WIDTH'(1000), WIDTH'(1), 1'b0, 0, res_d, res_b);
        chk("lit_plain_diff", res_d, WIDTH'(999));
        chk("lit_plain_bout", WIDTH'(res_b), WIDTH'(0));

        a = WIDTH'(1) << 64;
        run_op(a, WIDTH'(1), 1'b0, 1, res_d, res_b);
        chk("lit_xchunk_diff", res_d, {{(WIDTH-64){1'b0}}, {64{1'b1}}});
        chk("lit_xchunk_bout", WIDTH'(res_b), WIDTH'(0));

        run_op('0, WIDTH'(1), 1'b0, 0, res_d, res_b);
        chk("lit_under_diff", res_d, ones);
        chk("lit_under_bout", WIDTH'(res_b), WIDTH'(1));

        a = rnd_wide() | WIDTH'(1);
        run_op(a, a, 1'b1, 5, res_d, res_b);
        chk("lit_eq_bin_diff", res_d, ones);
        chk("lit_eq_bin_bout", WIDTH'(res_b), WIDTH'(1));

        run_op(WIDTH'(7), WIDTH'(7), 1'b0, 0, res_d, res_b);
        chk("lit_b2b_diff", res_d, '0);
        chk("lit_b2b_bout", WIDTH'(res_b), WIDTH'(0));

`ifdef SEG_SUB_OVF_EN
        run_op(~msb, ones, 1'b0, 0, res_d, res_b);
        chk("lit_ovf_diff", res_d, msb);
        chk("lit_ovf_bout", WIDTH'(res_b), WIDTH'(1));
        chk("lit_ovf_flag", WIDTH'(ovf), WIDTH'(1));
        run_op(WIDTH'(5), WIDTH'(3), 1'b0, 0, res_d, res_b);
        chk("lit_noovf_diff", res_d, WIDTH'(2));
        chk("lit_noovf_flag", WIDTH'(ovf), WIDTH'(0));
`endif

        // Abort an operation mid-RUN; no result may ever appear.
        in_valid = 1'b1; x = WIDTH'(123); y = WIDTH'(45); bin = 1'b0;
        @(posedge clk); #2;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #2; end
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        chk("abort_state", WIDTH'({in_ready, out_valid, bout}), WIDTH'(3'b100));
        chk("abort_diff", diff, '0);
        seen = 0;
        repeat (N + 3) begin
            @(posedge clk); #2;
            if (out_valid) seen++;
        end
        chk("abort_no_result", WIDTH'(seen), WIDTH'(0));

        for (int i = 0; i < 25; i++) begin
            a = rnd_wide();
            b = ($urandom_range(0, 5) == 0) ? a : rnd_wide();
            run_op(a, b, 1'($urandom), $urandom_range(0, 3), res_d, res_b);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
